align_pp_multilane: RTL

//  Multi-lane, parametrised successor of the single-lane partial-product aligner in the MAC subsystem.
//  - Per lane: right-shifts a sign-magnitude partial product by (max_exp - exp).
//  - Per lane: produces a sticky bit from the shifted-out bits.
//  - Per lane: converts the result to two's complement for the adder tree.
//  - Two-stage elastic pipeline with a valid/ready handshake; sits between the exponent-max stage and the adder tree.

---
 rtl/align_pp_multilane.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/align_pp_multilane.sv
// Multi-lane partial-product aligner: per-lane right shift to a common exponent with
// sticky collection, then sign-magnitude to two's-complement, in a two-stage elastic pipe.
module align_pp_multilane #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned MAN_W   = 3,
  parameter int unsigned EXP_W   = 6,
  parameter int unsigned ALIGN_W = 14,
  parameter int unsigned QF_W    = 5
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [LANES*(MAN_W+1)-1:0]     i_pp,
  input  logic [LANES*EXP_W-1:0]         i_exp,
  input  logic [EXP_W-1:0]               i_max_exp,
  input  logic [QF_W-1:0]                i_Q_frac,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [LANES*(ALIGN_W+1)-1:0]   o_align_pp,
  output logic [LANES-1:0]               o_sticky,
  output logic [LANES-1:0]               o_exp_err,
  output logic [EXP_W-1:0]               o_max_exp,
  output logic [QF_W-1:0]                o_Q_frac
);

  localparam int unsigned      PP_W      = MAN_W + 1;
  localparam int unsigned      WIDE_W    = 2 * ALIGN_W;
  localparam logic [EXP_W:0]   ALIGN_LIM = (EXP_W+1)'(ALIGN_W);
  localparam logic [ALIGN_W:0] ONE       = {{ALIGN_W{1'b0}}, 1'b1};

  // Stage 1 registers
  logic                           v1_q, v1_d;
  logic [LANES-1:0][ALIGN_W-1:0]  mag_q, mag_d;
  logic [LANES-1:0]               sign_q, sign_d;
  logic [LANES-1:0]               sticky1_q, sticky1_d;
  logic [LANES-1:0]               err1_q, err1_d;
  logic [EXP_W-1:0]               max1_q, max1_d;
  logic [QF_W-1:0]                qf1_q, qf1_d;

  // Stage 2 registers
  logic                           v2_q, v2_d;
  logic [LANES-1:0][ALIGN_W:0]    align_q, align_d;
  logic [LANES-1:0]               sticky2_q, sticky2_d;
  logic [LANES-1:0]               err2_q, err2_d;
  logic [EXP_W-1:0]               max2_q, max2_d;
  logic [QF_W-1:0]                qf2_q, qf2_d;

  logic                           load1, load2, accept;
  logic [LANES-1:0][EXP_W:0]      diff;
  logic [LANES-1:0][WIDE_W-1:0]   wide;
  logic [LANES-1:0][MAN_W-1:0]    man_in;

  assign load2   = !v2_q || i_ready;
  assign load1   = !v1_q || load2;
  assign o_ready = load1;
  assign accept  = i_valid && load1;

  // Stage 1: the shifter works on a double-width word so that the low half
  // holds exactly the bits that fell below the LSB.
  always_comb begin
    v1_d      = v1_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    sticky1_d = sticky1_q;
    err1_d    = err1_q;
    max1_d    = max1_q;
    qf1_d     = qf1_q;
    diff      = '0;
    wide      = '0;
    man_in    = '0;
    if (load1) begin
      v1_d = i_valid;
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      man_in[l] = i_pp[l*PP_W +: MAN_W];
      diff[l]   = {1'b0, i_max_exp} - {1'b0, i_exp[l*EXP_W +: EXP_W]};
      wide[l]   = {man_in[l], {(WIDE_W-MAN_W){1'b0}}} >> diff[l];
      if (accept) begin
        sign_d[l] = i_pp[l*PP_W + MAN_W];
        if (diff[l][EXP_W]) begin
          err1_d[l]    = 1'b1;
          mag_d[l]     = '0;
          sticky1_d[l] = 1'b0;
        end else if (diff[l] >= ALIGN_LIM) begin
          err1_d[l]    = 1'b0;
          mag_d[l]     = '0;
          sticky1_d[l] = |man_in[l];
        end else begin
          err1_d[l]    = 1'b0;
          mag_d[l]     = wide[l][WIDE_W-1 -: ALIGN_W];
          sticky1_d[l] = |wide[l][ALIGN_W-1:0];
        end
      end
    end
    if (accept) begin
      max1_d = i_max_exp;
      qf1_d  = i_Q_frac;
    end
  end

  // Stage 2: negation of a zero magnitude wraps back to zero, so no negative zero.
  always_comb begin
    v2_d      = v2_q;
    align_d   = align_q;
    sticky2_d = sticky2_q;
    err2_d    = err2_q;
    max2_d    = max2_q;
    qf2_d     = qf2_q;
    if (load2) begin
      v2_d = v1_q;
    end
    if (load2 && v1_q) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        align_d[l] = sign_q[l] ? (~{1'b0, mag_q[l]}) + ONE : {1'b0, mag_q[l]};
      end
      sticky2_d = sticky1_q;
      err2_d    = err1_q;
      max2_d    = max1_q;
      qf2_d     = qf1_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1_q      <= 1'b0;
      mag_q     <= '0;
      sign_q    <= '0;
      sticky1_q <= '0;
      err1_q    <= '0;
      max1_q    <= '0;
      qf1_q     <= '0;
      v2_q      <= 1'b0;
      align_q   <= '0;
      sticky2_q <= '0;
      err2_q    <= '0;
      max2_q    <= '0;
      qf2_q     <= '0;
    end else begin
      v1_q      <= v1_d;
      mag_q     <= mag_d;
      sign_q    <= sign_d;
      sticky1_q <= sticky1_d;
      err1_q    <= err1_d;
      max1_q    <= max1_d;
      qf1_q     <= qf1_d;
      v2_q      <= v2_d;
      align_q   <= align_d;
      sticky2_q <= sticky2_d;
      err2_q    <= err2_d;
      max2_q    <= max2_d;
      qf2_q     <= qf2_d;
    end
  end

  assign o_valid    = v2_q;
  assign o_align_pp = align_q;
  assign o_sticky   = sticky2_q;
  assign o_exp_err  = err2_q;
  assign o_max_exp  = max2_q;
  assign o_Q_frac   = qf2_q;

endmodule
